// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX line among byte requesters.
// Frames carry a start bit, LSB-first data and stop bit(s), timed by baud_tick.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          baud_tick,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          tx_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TN = OVERSAMPLE * STOP_BITS;
  localparam int TW = (TN > 1) ? $clog2(TN) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(TN - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           tick_q, tick_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [IW-1:0]           grant_q, grant_d;
  logic [IW-1:0]           last_q, last_d;
  logic                    tx_q, tx_d;
  logic                    done_q, done_d;

  logic [IW-1:0] win, idx;
  logic          any, accept;

  // First valid requester scanning upward from the one after last_q.
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((int'(last_q) + i) % NUM_REQ);
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

  assign accept    = any && (state_q == IDLE) && !reset;
  assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    grant_d = grant_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          grant_d = win;
          last_d  = win;
          tick_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == DATA_LAST) state_d = STOP;
            else bit_d = bit_q + 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (tick_q == STOP_LAST) begin
            tick_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // tx is registered, so it follows the state being entered.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      grant_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = (state_q != IDLE);
  assign grant_id = grant_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a tick-count frame model
// and a round-robin pick model.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int OS    = 8;
  localparam int SB    = 1;
  localparam int RW    = NR * DW;
  localparam int TOTAL = OS * (1 + DW + SB);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          baud_tick = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [RW-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic          tx, tx_busy, tx_done;
  logic [1:0]    grant_id;

  int n_cmp = 0;
  int n_bad = 0;
  int tick_per = 4;
  bit tick_en = 1'b1;
  int tick_ph = 0;
  int m_last = NR - 1;

  typedef struct {
    int tx_err;
    int busy_err;
    int rdy_err;
    int gid_err;
    int start_len;
    int min_len;
    int max_len;
    bit done_ok;
    bit to;
  } frame_res_t;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .OVERSAMPLE(OS), .STOP_BITS(SB)
  ) dut (
    .clk(clk), .reset(reset), .baud_tick(baud_tick),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx(tx), .tx_busy(tx_busy), .grant_id(grant_id), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick_ph++;
    baud_tick = tick_en && (tick_per > 0) && (tick_ph % tick_per == 0);
  end

  function automatic int rr_pick(int last, logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  // Line level after n ticks of the frame: start, data LSB first, stop.
  function automatic logic exp_bit(int n, logic [DW-1:0] d);
    int k;
    k = n / OS;
    if (k == 0) return 1'b0;
    if (k <= DW) return d[k-1];
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] slot(logic [RW-1:0] v, int i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic [NR-1:0] rand_valid();
    logic [NR-1:0] v;
    v = NR'($urandom);
    if (v == '0) v = NR'(1) << $urandom_range(NR-1);
    return v;
  endfunction

  task automatic await_grant(output int g, output int waited);
    g = -1;
    waited = 0;
    #1;
    forever begin
      if (req_ready != '0) begin
        for (int k = 0; k < NR; k++) if (req_ready[k]) g = k;
        if ($countones(req_ready) != 1) g = -2;
        return;
      end
      if (waited >= 400) return;
      @(negedge clk); #1;
      waited++;
    end
  endtask

  task automatic watch_frame(input int g, input logic [DW-1:0] d,
                             input logic [NR-1:0] v_after,
                             input logic [RW-1:0] data_after,
                             input bit scramble, input int stall_at,
                             input int stall_len, output frame_res_t r);
    int n = 0, cyc = 0, stall_left = 0, cur_k = 0, cur_len = 0, k;
    bit stalled = 0, early = 0;
    r = '{default: 0};
    r.min_len = 1 << 30;
    forever begin
      @(negedge clk);
      if (scramble && n < TOTAL) begin
        req_valid = NR'($urandom);
        req_data  = RW'($urandom);
      end else begin
        req_valid = v_after;
        req_data  = data_after;
      end
      if (!stalled && stall_len > 0 && n >= stall_at) begin
        stalled = 1;
        stall_left = stall_len;
        tick_en = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) tick_en = 1'b1;
      end
      #1;
      cyc++;
      if (n == TOTAL) begin
        if (tx !== 1'b1) r.tx_err++;
        if (tx_busy !== 1'b0) r.busy_err++;
        if (grant_id !== 2'(g)) r.gid_err++;
        r.done_ok = !early && (tx_done === 1'b1);
        if (cur_len < r.min_len) r.min_len = cur_len;
        if (cur_len > r.max_len) r.max_len = cur_len;
        tick_en = 1'b1;
        return;
      end
      k = n / OS;
      if (tx !== exp_bit(n, d)) r.tx_err++;
      if (tx_busy !== 1'b1) r.busy_err++;
      if (req_ready !== '0) r.rdy_err++;
      if (grant_id !== 2'(g)) r.gid_err++;
      if (tx_done !== 1'b0) early = 1;
      if (k != cur_k) begin
        if (cur_k == 0) r.start_len = cur_len;
        else begin
          if (cur_len < r.min_len) r.min_len = cur_len;
          if (cur_len > r.max_len) r.max_len = cur_len;
        end
        cur_k = k;
        cur_len = 0;
      end
      cur_len++;
      if (baud_tick) n++;
      if (cyc > 3000) begin
        r.to = 1;
        tick_en = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int g, w, e;
    frame_res_t r;
    reset = 1'b1;
    req_valid = '1;
    req_data = RW'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (tx !== 1'b1) begin
        n_bad++; $display("FAIL reset_tx: got %b expected 1", tx);
      end
      n_cmp++;
      if (tx_busy !== 1'b0) begin
        n_bad++; $display("FAIL reset_busy: got %b expected 0", tx_busy);
      end
      n_cmp++;
      if (req_ready !== '0) begin
        n_bad++; $display("FAIL reset_ready: got %b expected 0", req_ready);
      end
      n_cmp++;
      if (grant_id !== 2'd0) begin
        n_bad++; $display("FAIL reset_gid: got %0d expected 0", grant_id);
      end
      n_cmp++;
      if (tx_done !== 1'b0) begin
        n_bad++; $display("FAIL reset_done: got %b expected 0", tx_done);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    m_last = NR - 1;
    await_grant(g, w);
    e = rr_pick(m_last, req_valid);
    n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL reset_first_grant: got %0d expected %0d", g, e);
    end
    if (g >= 0) begin
      m_last = g;
      watch_frame(g, slot(req_data, g), '0, req_data, 0, -1, 0, r);
      n_cmp++;
      if (r.tx_err + r.busy_err + r.rdy_err + r.gid_err != 0 || r.to) begin
        n_bad++;
        $display("FAIL reset_frame: tx=%0d busy=%0d rdy=%0d gid=%0d to=%0d expected 0",
                 r.tx_err, r.busy_err, r.rdy_err, r.gid_err, r.to);
      end
    end
  endtask

  task automatic test_single();
    int g, w;
    frame_res_t r;
    logic [RW-1:0] d;
    tick_per = 4;
    d = RW'($urandom);
    d[2*DW +: DW] = 8'hA5;
    @(negedge clk);
    req_valid = 4'b0100;
    req_data = d;
    await_grant(g, w);
    n_cmp++;
    if (g !== 2 || w !== 0) begin
      n_bad++; $display("FAIL single_grant: got id %0d wait %0d expected 2 wait 0", g, w);
    end
    if (g < 0) return;
    m_last = g;
    watch_frame(g, 8'hA5, '0, d, 0, -1, 0, r);
    n_cmp++;
    if (r.tx_err + r.busy_err + r.rdy_err + r.gid_err != 0 || r.to) begin
      n_bad++;
      $display("FAIL single_frame: tx=%0d busy=%0d rdy=%0d gid=%0d to=%0d expected 0",
               r.tx_err, r.busy_err, r.rdy_err, r.gid_err, r.to);
    end
    n_cmp++;
    if (r.done_ok !== 1'b1) begin
      n_bad++; $display("FAIL single_done: got %0d expected 1", r.done_ok);
    end
    n_cmp++;
    if (r.start_len < 29 || r.start_len > 32) begin
      n_bad++; $display("FAIL single_start_len: got %0d expected 29..32", r.start_len);
    end
    n_cmp++;
    if (r.min_len !== 32 || r.max_len !== 32) begin
      n_bad++;
      $display("FAIL single_bit_len: got %0d..%0d expected 32", r.min_len, r.max_len);
    end
  endtask

  task automatic test_all_valid();
    int g, w, e;
    frame_res_t r;
    logic [RW-1:0] d;
    d = RW'($urandom);
    tick_per = $urandom_range(1, 4);
    @(negedge clk);
    reset = 1'b1;
    req_valid = '1;
    req_data = d;
    @(negedge clk); #1;
    n_cmp++;
    if (req_ready !== '0) begin
      n_bad++; $display("FAIL rr_reset_ready: got %b expected 0", req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    m_last = NR - 1;
    for (int i = 0; i < 5; i++) begin
      await_grant(g, w);
      e = rr_pick(m_last, 4'b1111);
      n_cmp++;
      if (g !== e || (i > 0 && w !== 0)) begin
        n_bad++;
        $display("FAIL rr_order_%0d: got id %0d wait %0d expected %0d", i, g, w, e);
      end
      if (g < 0) return;
      m_last = g;
      watch_frame(g, slot(d, g), (i < 4) ? 4'b1111 : 4'b0000, d, 0, -1, 0, r);
      n_cmp++;
      if (r.tx_err + r.busy_err + r.rdy_err + r.gid_err != 0 || r.to || !r.done_ok) begin
        n_bad++;
        $display("FAIL rr_frame_%0d: tx=%0d busy=%0d rdy=%0d done=%0d expected 0 0 0 1",
                 i, r.tx_err, r.busy_err, r.rdy_err, r.done_ok);
      end
    end
  endtask

  task automatic test_priority();
    int g, w, e;
    frame_res_t r;
    logic [RW-1:0] d;
    logic [NR-1:0] v;
    d = RW'($urandom);
    tick_per = 3;
    @(negedge clk);
    req_valid = 4'b0010;
    req_data = d;
    v = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      await_grant(g, w);
      e = rr_pick(m_last, v);
      n_cmp++;
      if (g !== e) begin
        n_bad++; $display("FAIL prio_grant_%0d: got %0d expected %0d", i, g, e);
      end
      if (g < 0) return;
      m_last = g;
      if (i == 0) v = 4'b1001;
      else v[g] = 1'b0;
      watch_frame(g, slot(d, g), v, d, 1, -1, 0, r);
      n_cmp++;
      if (r.tx_err + r.busy_err + r.rdy_err + r.gid_err != 0 || r.to || !r.done_ok) begin
        n_bad++;
        $display("FAIL prio_frame_%0d: tx=%0d busy=%0d rdy=%0d done=%0d expected 0 0 0 1",
                 i, r.tx_err, r.busy_err, r.rdy_err, r.done_ok);
      end
    end
  endtask

  task automatic test_reset_mid();
    int g, w, e, n, cyc, dones;
    frame_res_t r;
    logic [RW-1:0] d;
    d = RW'($urandom);
    tick_per = 4;
    @(negedge clk);
    req_valid = 4'b0100;
    req_data = d;
    await_grant(g, w);
    if (g < 0) begin
      n_cmp++; n_bad++; $display("FAIL mid_grant: got %0d expected 2", g);
      return;
    end
    n = 0;
    cyc = 0;
    while (n < 4 * OS + 2 && cyc < 2000) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      cyc++;
      if (baud_tick) n++;
    end
    n_cmp++;
    if (tx_busy !== 1'b1) begin
      n_bad++; $display("FAIL mid_busy_before: got %b expected 1", tx_busy);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_abort: got tx %b busy %b expected 1 0", tx, tx_busy);
    end
    dones = tx_done;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (tx_done === 1'b1 || tx !== 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++; $display("FAIL mid_no_done: got %0d events expected 0", dones);
    end
    @(negedge clk);
    req_valid = 4'b1010;
    m_last = NR - 1;
    await_grant(g, w);
    e = rr_pick(m_last, 4'b1010);
    n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL mid_regrant: got %0d expected %0d", g, e);
    end
    if (g < 0) return;
    m_last = g;
    watch_frame(g, slot(d, g), '0, d, 0, -1, 0, r);
    n_cmp++;
    if (r.tx_err + r.busy_err + r.rdy_err + r.gid_err != 0 || r.to || !r.done_ok) begin
      n_bad++;
      $display("FAIL mid_frame: tx=%0d busy=%0d rdy=%0d done=%0d expected 0 0 0 1",
               r.tx_err, r.busy_err, r.rdy_err, r.done_ok);
    end
  endtask

  task automatic test_stall();
    int g, w, e;
    frame_res_t r;
    logic [RW-1:0] d;
    d = RW'($urandom);
    tick_per = 4;
    @(negedge clk);
    req_valid = 4'b1000;
    req_data = d;
    await_grant(g, w);
    e = rr_pick(m_last, 4'b1000);
    n_cmp++;
    if (g !== e) begin
      n_bad++; $display("FAIL stall_grant: got %0d expected %0d", g, e);
    end
    if (g < 0) return;
    m_last = g;
    watch_frame(g, slot(d, g), '0, d, 1, 3, 200, r);
    n_cmp++;
    if (r.tx_err + r.busy_err + r.rdy_err + r.gid_err != 0 || r.to || !r.done_ok) begin
      n_bad++;
      $display("FAIL stall_frame: tx=%0d busy=%0d rdy=%0d done=%0d expected 0 0 0 1",
               r.tx_err, r.busy_err, r.rdy_err, r.done_ok);
    end
    n_cmp++;
    if (r.start_len < 200) begin
      n_bad++; $display("FAIL stall_start_len: got %0d expected >= 200", r.start_len);
    end
  endtask

  task automatic test_random();
    int g, w, e;
    frame_res_t r;
    logic [RW-1:0] cd, nd;
    logic [NR-1:0] cv, nv;
    cv = rand_valid();
    cd = RW'($urandom);
    @(negedge clk);
    req_valid = cv;
    req_data = cd;
    for (int i = 0; i < 8; i++) begin
      tick_per = $urandom_range(1, 5);
      await_grant(g, w);
      e = rr_pick(m_last, cv);
      n_cmp++;
      if (g !== e || (i > 0 && w !== 0)) begin
        n_bad++;
        $display("FAIL rand_grant_%0d: got id %0d wait %0d expected %0d", i, g, w, e);
      end
      if (g < 0) return;
      m_last = g;
      nv = (i < 7) ? rand_valid() : '0;
      nd = RW'($urandom);
      watch_frame(g, slot(cd, g), nv, nd, 1, -1, 0, r);
      n_cmp++;
      if (r.tx_err + r.busy_err + r.rdy_err + r.gid_err != 0 || r.to || !r.done_ok) begin
        n_bad++;
        $display("FAIL rand_frame_%0d: tx=%0d busy=%0d rdy=%0d done=%0d expected 0 0 0 1",
                 i, r.tx_err, r.busy_err, r.rdy_err, r.done_ok);
      end
      cv = nv;
      cd = nd;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_priority();
    test_reset_mid();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
